// File: rtl/food_placer_if.sv
// Bundles the food_placer signals: game-FSM request/status, prng handshake,
// and occupancy lookup. The placer takes the slave modport.
interface food_placer_if #(
  parameter int unsigned POS_W = 6
) ();
  logic             place_req;
  logic             busy;
  logic             done;
  logic             full;
  logic [POS_W-1:0] food_pos;
  logic             rand_req;
  logic [POS_W-1:0] rand_num;
  logic [POS_W-1:0] occ_addr;
  logic             occ_hit;

  modport slave (
    input  place_req, rand_num, occ_hit,
    output busy, done, full, food_pos, rand_req, occ_addr
  );

  modport master (
    output place_req, rand_num, occ_hit,
    input  busy, done, full, food_pos, rand_req, occ_addr
  );
endinterface

// File: rtl/food_placer.sv
// Picks a free board cell for food: random candidates from the prng with retry,
// then a wrapping linear scan, reporting board-full when every cell is taken.
module food_placer #(
  parameter int unsigned POS_W     = 6,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic        clka,
  input  logic        restart_n,
  food_placer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CHECK,
    SCAN,
    DONE,
    FULL
  } state_e;

  localparam logic [POS_W-1:0] ONE       = {{(POS_W-1){1'b0}}, 1'b1};
  // Last scan count before FULL: 2**POS_W-1 occupied scan cells.
  localparam logic [POS_W-1:0] SCAN_LAST = {{(POS_W-1){1'b1}}, 1'b0};
  localparam logic [7:0]       TRY_LAST  = 8'(MAX_TRIES - 1);

  state_e           state_q, state_d;
  logic [7:0]       try_q, try_d;
  logic [POS_W-1:0] scan_ptr_q, scan_ptr_d;
  logic [POS_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [POS_W-1:0] food_q, food_d;
  logic             full_q, full_d;
  logic             busy_q;
  logic             rand_req_c;
  logic             done_c;
  logic [POS_W-1:0] occ_addr_c;

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      state_q    <= IDLE;
      try_q      <= '0;
      scan_ptr_q <= '0;
      scan_cnt_q <= '0;
      food_q     <= '0;
      full_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      try_q      <= try_d;
      scan_ptr_q <= scan_ptr_d;
      scan_cnt_q <= scan_cnt_d;
      food_q     <= food_d;
      full_q     <= full_d;
      busy_q     <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d    = state_q;
    try_d      = try_q;
    scan_ptr_d = scan_ptr_q;
    scan_cnt_d = scan_cnt_q;
    food_d     = food_q;
    full_d     = full_q;
    rand_req_c = 1'b0;
    done_c     = 1'b0;
    occ_addr_c = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.place_req) begin
          state_d    = REQ;
          full_d     = 1'b0;
          try_d      = '0;
          scan_cnt_d = '0;
        end
      end
      REQ: begin
        rand_req_c = 1'b1;
        state_d    = WAIT;
      end
      WAIT: state_d = CHECK;
      CHECK: begin
        occ_addr_c = bus.rand_num;
        if (!bus.occ_hit) begin
          food_d  = bus.rand_num;
          state_d = DONE;
        end else begin
          try_d = try_q + 8'd1;
          if (try_q == TRY_LAST) begin
            scan_ptr_d = bus.rand_num + ONE;
            state_d    = SCAN;
          end else begin
            state_d = REQ;
          end
        end
      end
      SCAN: begin
        occ_addr_c = scan_ptr_q;
        if (!bus.occ_hit) begin
          food_d  = scan_ptr_q;
          state_d = DONE;
        end else begin
          scan_ptr_d = scan_ptr_q + ONE;
          scan_cnt_d = scan_cnt_q + ONE;
          if (scan_cnt_q == SCAN_LAST) state_d = FULL;
        end
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      FULL: begin
        done_c  = 1'b1;
        full_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_c;
  assign bus.full     = full_q;
  assign bus.food_pos = food_q;
  assign bus.rand_req = rand_req_c;
  assign bus.occ_addr = occ_addr_c;

endmodule

// File: tb/tb_food_placer.sv
// Directed bench for food_placer with a sequence-driven prng model and a
// 64-cell occupancy map answering lookups combinationally.
module tb_food_placer;

  logic clka;
  logic restart_n;

  food_placer_if #(.POS_W(6)) bus ();

  food_placer #(.POS_W(6), .MAX_TRIES(8)) dut (
    .clka      (clka),
    .restart_n (restart_n),
    .bus       (bus.slave)
  );

  initial clka = 1'b0;
  always #5 clka = ~clka;

  logic [63:0]  occ;
  logic [5:0]   rseq [8];
  int unsigned  rlen = 1;
  int unsigned  rcnt = 0;
  int unsigned  rstart = 0;
  int unsigned  vectors = 0;
  int unsigned  errs = 0;

  assign bus.occ_hit = occ[bus.occ_addr];

  // prng model: a new value appears right after each rand_req pulse
  always @(negedge clka) begin
    if (bus.rand_req) begin
      bus.rand_num = rseq[(rcnt - rstart) % rlen];
      rcnt = rcnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input bit hold);
    @(negedge clka);
    rstart = rcnt;
    bus.place_req = 1'b1;
    @(posedge clka);
    #1;
    if (!hold) bus.place_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat);
    bit got;
    got = 0;
    lat = 0;
    while (!got && lat < 200) begin
      @(negedge clka);
      lat++;
      if (bus.done) got = 1;
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    int lat;
    restart_n     = 1'b0;
    bus.place_req = 1'b0;
    occ           = '0;
    rseq[0]       = 6'h2A;
    #1;
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_full", 32'(bus.full), 0);
    chk("rst_rand_req", 32'(bus.rand_req), 0);
    chk("rst_food_pos", 32'(bus.food_pos), 0);
    chk("rst_occ_addr", 32'(bus.occ_addr), 0);
    @(negedge clka);
    @(negedge clka);
    restart_n = 1'b1;

    // empty board, first candidate free
    occ = '0; rseq[0] = 6'h2A; rlen = 1;
    start_req(0);
    chk("t2_busy_c1", 32'(bus.busy), 1);
    wait_done("t2", lat);
    chk("t2_latency", 32'(lat), 4);
    chk("t2_food_pos", 32'(bus.food_pos), 32'h2A);
    chk("t2_full", 32'(bus.full), 0);
    chk("t2_pulses", rcnt - rstart, 1);
    @(negedge clka);
    chk("t2_done_1cyc", 32'(bus.done), 0);
    chk("t2_busy_after", 32'(bus.busy), 0);

    // two collisions then a free cell
    occ = '0; occ[6'h2A] = 1'b1; occ[6'h11] = 1'b1;
    rseq[0] = 6'h2A; rseq[1] = 6'h11; rseq[2] = 6'h05; rlen = 3;
    start_req(0);
    wait_done("t3", lat);
    chk("t3_latency", 32'(lat), 10);
    chk("t3_food_pos", 32'(bus.food_pos), 32'h05);
    chk("t3_pulses", rcnt - rstart, 3);

    // retries exhausted, scan wraps past 0x3F
    occ = '0; occ[6'h3E] = 1'b1; occ[6'h3F] = 1'b1; occ[6'h00] = 1'b1;
    rseq[0] = 6'h3E; rlen = 1;
    start_req(0);
    wait_done("t4", lat);
    chk("t4_latency", 32'(lat), 28);
    chk("t4_food_pos", 32'(bus.food_pos), 32'h01);
    chk("t4_pulses", rcnt - rstart, 8);
    chk("t4_full", 32'(bus.full), 0);

    // board completely full
    occ = '1; rseq[0] = 6'h3E; rlen = 1;
    start_req(0);
    wait_done("t5", lat);
    chk("t5_latency", 32'(lat), 88);
    chk("t5_pulses", rcnt - rstart, 8);
    @(negedge clka);
    chk("t5_full", 32'(bus.full), 1);
    chk("t5_done_1cyc", 32'(bus.done), 0);
    chk("t5_busy", 32'(bus.busy), 0);
    chk("t5_food_kept", 32'(bus.food_pos), 32'h01);

    // reset while scanning
    occ = '1; rseq[0] = 6'h3E; rlen = 1;
    start_req(0);
    repeat (30) @(negedge clka);
    chk("t1_busy_in_scan", 32'(bus.busy), 1);
    restart_n = 1'b0;
    #1;
    chk("t1_busy", 32'(bus.busy), 0);
    chk("t1_done", 32'(bus.done), 0);
    chk("t1_full", 32'(bus.full), 0);
    chk("t1_rand_req", 32'(bus.rand_req), 0);
    chk("t1_food_pos", 32'(bus.food_pos), 0);
    chk("t1_occ_addr", 32'(bus.occ_addr), 0);
    @(negedge clka);
    @(negedge clka);
    restart_n = 1'b1;
    occ = '0; rseq[0] = 6'h2A; rlen = 1;
    start_req(0);
    wait_done("t1_after", lat);
    chk("t1_after_latency", 32'(lat), 4);
    chk("t1_after_food", 32'(bus.food_pos), 32'h2A);

    // place_req held high across a whole request
    occ = '0; rseq[0] = 6'h10; rseq[1] = 6'h20; rlen = 2;
    start_req(1);
    wait_done("t6a", lat);
    chk("t6a_latency", 32'(lat), 4);
    chk("t6a_pulses", rcnt - rstart, 1);
    chk("t6a_food_pos", 32'(bus.food_pos), 32'h10);
    @(negedge clka);
    chk("t6_idle_busy", 32'(bus.busy), 0);
    chk("t6_idle_rand_req", 32'(bus.rand_req), 0);
    @(negedge clka);
    chk("t6_req2_rand_req", 32'(bus.rand_req), 1);
    chk("t6_req2_busy", 32'(bus.busy), 1);
    bus.place_req = 1'b0;
    wait_done("t6b", lat);
    chk("t6b_latency", 32'(lat), 3);
    chk("t6b_food_pos", 32'(bus.food_pos), 32'h20);
    chk("t6b_pulses", rcnt - rstart, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
